// File: rtl/conv2d_mac_accumulator.sv
// rtl/conv2d_mac_accumulator.sv - 3x3 conv MAC with cross-channel partial-sum row buffer and AXI-Stream output
module conv2d_mac_accumulator #(
  parameter int DATA_WIDTH     = 16,
  parameter int FRAC_BITS      = 8,
  parameter int ACC_WIDTH      = 40,
  parameter int MAX_IMAGE_SIZE = 128
) (
  input  logic                         clk,
  input  logic                         Reset,
  input  logic signed [DATA_WIDTH-1:0] in_window_00,
  input  logic signed [DATA_WIDTH-1:0] in_window_01,
  input  logic signed [DATA_WIDTH-1:0] in_window_02,
  input  logic signed [DATA_WIDTH-1:0] in_window_10,
  input  logic signed [DATA_WIDTH-1:0] in_window_11,
  input  logic signed [DATA_WIDTH-1:0] in_window_12,
  input  logic signed [DATA_WIDTH-1:0] in_window_20,
  input  logic signed [DATA_WIDTH-1:0] in_window_21,
  input  logic signed [DATA_WIDTH-1:0] in_window_22,
  input  logic signed [DATA_WIDTH-1:0] weight_00,
  input  logic signed [DATA_WIDTH-1:0] weight_01,
  input  logic signed [DATA_WIDTH-1:0] weight_02,
  input  logic signed [DATA_WIDTH-1:0] weight_10,
  input  logic signed [DATA_WIDTH-1:0] weight_11,
  input  logic signed [DATA_WIDTH-1:0] weight_12,
  input  logic signed [DATA_WIDTH-1:0] weight_20,
  input  logic signed [DATA_WIDTH-1:0] weight_21,
  input  logic signed [DATA_WIDTH-1:0] weight_22,
  input  logic signed [DATA_WIDTH-1:0] bias,
  input  logic [7:0]                   IMAGE_SIZE,
  input  logic                         first_channel,
  input  logic                         last_channel,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic                         Done_1row
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int RW = PW + 2;
  localparam int TW = PW + 4;
  localparam int AW = (MAX_IMAGE_SIZE > 1) ? $clog2(MAX_IMAGE_SIZE) : 1;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0] w_win [9];
  logic signed [DATA_WIDTH-1:0] w_wgt [9];
  logic signed [PW-1:0]         w_prod [9];
  logic                         w_stall;
  logic                         w_accept;
  logic [7:0]                   w_last_col;
  logic signed [ACC_WIDTH-1:0]  w_psum_in;
  logic signed [ACC_WIDTH-1:0]  w_acc;
  logic signed [ACC_WIDTH-1:0]  w_biased;
  logic signed [ACC_WIDTH-1:0]  w_y;
  logic [DATA_WIDTH-1:0]        w_sat;

  logic [7:0]                   r_col;
  logic                         r_s1_valid, r_s2_valid, r_s3_valid;
  logic                         r_s1_first, r_s2_first, r_s3_first;
  logic                         r_s1_last, r_s2_last, r_s3_last;
  logic [7:0]                   r_s1_col, r_s2_col, r_s3_col;
  logic signed [PW-1:0]         r_s1_prod [9];
  logic signed [RW-1:0]         r_s2_row [3];
  logic signed [TW-1:0]         r_s3_sum;
  logic signed [ACC_WIDTH-1:0]  r_s1_psum, r_s2_psum, r_s3_psum;
  logic signed [ACC_WIDTH-1:0]  r_psum [MAX_IMAGE_SIZE];
  logic                         r_out_valid;
  logic [DATA_WIDTH-1:0]        r_out_data;
  logic                         r_out_last;

  assign w_win = '{in_window_00, in_window_01, in_window_02,
                   in_window_10, in_window_11, in_window_12,
                   in_window_20, in_window_21, in_window_22};
  assign w_wgt = '{weight_00, weight_01, weight_02,
                   weight_10, weight_11, weight_12,
                   weight_20, weight_21, weight_22};

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      w_prod[k] = PW'(w_win[k]) * PW'(w_wgt[k]);
    end
  end

  assign w_last_col = IMAGE_SIZE - 8'd1;
  assign w_stall    = r_out_valid & ~m_axis_tready;
  assign in_ready   = ~Reset & ~w_stall;
  assign w_accept   = in_valid & in_ready;
  assign Done_1row  = w_accept & (r_col == w_last_col);

  // S4: the psum read travelled with the window, so no read-after-write forwarding is needed
  assign w_psum_in = r_s3_first ? '0 : r_s3_psum;
  assign w_acc     = w_psum_in + ACC_WIDTH'(r_s3_sum);
  assign w_biased  = w_acc + (ACC_WIDTH'(bias) <<< FRAC_BITS);
  assign w_y       = w_biased >>> FRAC_BITS;

  always_comb begin
    if (w_y > SAT_MAX) begin
      w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (w_y < SAT_MIN) begin
      w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      w_sat = w_y[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_col       <= '0;
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s3_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_col <= (r_col == w_last_col) ? 8'd0 : r_col + 8'd1;
      end
      if (!w_stall) begin
        r_s1_valid  <= w_accept;
        r_s2_valid  <= r_s1_valid;
        r_s3_valid  <= r_s2_valid;
        r_out_valid <= r_s3_valid & r_s3_last;
        if (r_s3_valid && r_s3_last) begin
          r_out_data <= w_sat;
          r_out_last <= (r_s3_col == w_last_col);
        end
      end
    end
  end

  // Datapath and psum storage carry no reset; the valid chain qualifies them
  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_s1_prod  <= w_prod;
      r_s1_first <= first_channel;
      r_s1_last  <= last_channel;
      r_s1_col   <= r_col;
      r_s1_psum  <= r_psum[r_col[AW-1:0]];

      for (int r = 0; r < 3; r++) begin
        r_s2_row[r] <= RW'(r_s1_prod[3*r]) + RW'(r_s1_prod[3*r+1]) + RW'(r_s1_prod[3*r+2]);
      end
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_s2_col   <= r_s1_col;
      r_s2_psum  <= r_s1_psum;

      r_s3_sum   <= TW'(r_s2_row[0]) + TW'(r_s2_row[1]) + TW'(r_s2_row[2]);
      r_s3_first <= r_s2_first;
      r_s3_last  <= r_s2_last;
      r_s3_col   <= r_s2_col;
      r_s3_psum  <= r_s2_psum;

      if (r_s3_valid && !r_s3_last) begin
        r_psum[r_s3_col[AW-1:0]] <= w_acc;
      end
    end
  end

  assign m_axis_tvalid = r_out_valid;
  assign m_axis_tdata  = r_out_data;
  assign m_axis_tlast  = r_out_last;

endmodule

// File: tb/tb_conv2d_mac_accumulator.sv
// tb/tb_conv2d_mac_accumulator.sv - directed vector bench for conv2d_mac_accumulator
module tb_conv2d_mac_accumulator;

  logic               clk;
  logic               Reset;
  logic signed [15:0] win [9];
  logic signed [15:0] wgt [9];
  logic signed [15:0] bias;
  logic [7:0]         IMAGE_SIZE;
  logic               first_channel, last_channel, in_valid, in_ready;
  logic [15:0]        m_axis_tdata;
  logic               m_axis_tvalid, m_axis_tready, m_axis_tlast, Done_1row;

  conv2d_mac_accumulator #(
    .DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(40), .MAX_IMAGE_SIZE(128)
  ) dut (
    .clk(clk), .Reset(Reset),
    .in_window_00(win[0]), .in_window_01(win[1]), .in_window_02(win[2]),
    .in_window_10(win[3]), .in_window_11(win[4]), .in_window_12(win[5]),
    .in_window_20(win[6]), .in_window_21(win[7]), .in_window_22(win[8]),
    .weight_00(wgt[0]), .weight_01(wgt[1]), .weight_02(wgt[2]),
    .weight_10(wgt[3]), .weight_11(wgt[4]), .weight_12(wgt[5]),
    .weight_20(wgt[6]), .weight_21(wgt[7]), .weight_22(wgt[8]),
    .bias(bias), .IMAGE_SIZE(IMAGE_SIZE),
    .first_channel(first_channel), .last_channel(last_channel),
    .in_valid(in_valid), .in_ready(in_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .Done_1row(Done_1row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [8:0][15:0] taps;
    logic [8:0][15:0] wts;
    logic [15:0]      b;
    logic [15:0]      exp;
  } vec_t;

  typedef struct packed {
    logic [15:0] d;
    logic        l;
  } out_t;

  vec_t vecs [8];
  out_t exp_q [$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic l);
    out_t e;
    e.d = d;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [15:0] tap, input logic [15:0] wt, input logic f, input logic l);
    int n = 0;
    @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      win[k] = tap;
      wgt[k] = wt;
    end
    first_channel = f;
    last_channel  = l;
    in_valid      = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 1, 0);
  endtask

  task automatic run_channels(input int nch);
    for (int ch = 0; ch < nch; ch++) begin
      for (int c = 0; c < int'(IMAGE_SIZE); c++) begin
        send(16'(256 + 16 * c), 16'h0100, ch == 0, ch == nch - 1);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("outputs_missing", exp_q.size(), 0);
    repeat (6) @(negedge clk);
  endtask

  // Output monitor: scoreboard order, hold-while-stalled, in_ready under stall
  always begin : mon
    out_t        e;
    logic        prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && !Reset) begin
        if (m_axis_tvalid && !m_axis_tready) chk("in_ready_stall", in_ready, 0);
        if (prev_stall) begin
          chk("hold_tvalid", m_axis_tvalid, 1);
          chk("hold_tdata", m_axis_tdata, prev_data);
          chk("hold_tlast", m_axis_tlast, prev_last);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", m_axis_tdata, 16'hxxxx);
          end else begin
            e = exp_q.pop_front();
            chk("stream_tdata", m_axis_tdata, e.d);
            chk("stream_tlast", m_axis_tlast, e.l);
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 8; i++) begin
      vecs[i].taps = {9{16'h0100}};
      vecs[i].wts  = {9{16'h0100}};
      vecs[i].b    = 16'h0000;
    end
    vecs[0].exp = 16'h0900;
    vecs[1].b   = 16'hFF00;
    vecs[1].exp = 16'h0800;
    vecs[2].taps = {9{16'h7FFF}};
    vecs[2].wts  = {9{16'h7FFF}};
    vecs[2].exp  = 16'h7FFF;
    vecs[3].taps = {9{16'h8000}};
    vecs[3].wts  = {9{16'h7FFF}};
    vecs[3].exp  = 16'h8000;
    for (int k = 0; k < 9; k++) vecs[4].taps[k] = 16'((k + 1) * 256);
    vecs[4].exp = 16'h2D00;
    for (int k = 0; k < 9; k++) vecs[5].taps[k] = 16'((k + 1) * 256);
    vecs[5].wts    = '0;
    vecs[5].wts[8] = 16'h0100;
    vecs[5].exp    = 16'h0900;
    for (int k = 0; k < 9; k++) vecs[6].taps[k] = 16'((k + 1) * 256);
    vecs[6].wts    = '0;
    vecs[6].wts[1] = 16'hFF00;
    vecs[6].b      = 16'h0080;
    vecs[6].exp    = 16'hFE80;
    vecs[7].taps = {9{16'h0001}};
    vecs[7].wts  = {9{16'hFFFF}};
    vecs[7].exp  = 16'hFFFF;

    Reset = 1'b1;
    in_valid = 1'b0;
    first_channel = 1'b0;
    last_channel = 1'b0;
    m_axis_tready = 1'b1;
    IMAGE_SIZE = 8'd4;
    bias = '0;
    for (int k = 0; k < 9; k++) begin
      win[k] = '0;
      wgt[k] = '0;
    end
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_tdata", m_axis_tdata, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_done", Done_1row, 0);
    Reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Single-channel vectors, one window at a time, IMAGE_SIZE=4
    for (int i = 0; i < 8; i++) begin
      int lat;
      @(negedge clk);
      for (int k = 0; k < 9; k++) begin
        win[k] = vecs[i].taps[k];
        wgt[k] = vecs[i].wts[k];
      end
      bias = vecs[i].b;
      first_channel = 1'b1;
      last_channel = 1'b1;
      in_valid = 1'b1;
      #1;
      chk("done_1row", Done_1row, (i % 4) == 3);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!m_axis_tvalid && lat < 12) begin
        @(negedge clk);
        lat++;
      end
      chk("latency", lat, 4);
      chk("vec_tdata", m_axis_tdata, vecs[i].exp);
      chk("vec_tlast", m_axis_tlast, (i % 4) == 3);
    end
    bias = '0;

    // Three channels, IMAGE_SIZE=8, streamed back to back
    @(negedge clk);
    IMAGE_SIZE = 8'd8;
    for (int c = 0; c < 8; c++) push_exp(16'(27 * (256 + 16 * c)), c == 7);
    mon_en = 1'b1;
    run_channels(3);
    wait_drain();

    // Backpressure: tready low for 5 cycles while outputs stream
    for (int i = 0; i < 8; i++) push_exp(16'(576 * (i + 1)), i == 7);
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'(64 * (i + 1)), 16'h0100, 1'b1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        repeat (7) @(negedge clk);
        m_axis_tready = 1'b0;
        repeat (5) @(negedge clk);
        m_axis_tready = 1'b1;
      end
    join
    wait_drain();

    // Reset mid-row with a pending output, then restart from channel 0
    for (int c = 0; c < 8; c++) send(16'h0300, 16'h0100, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) send(16'h0300, 16'h0100, 1'b0, 1'b0);
    @(negedge clk);
    m_axis_tready = 1'b0;
    send(16'h0100, 16'h0100, 1'b1, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!m_axis_tvalid && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("pending_before_rst", m_axis_tvalid, 1);
    chk("pending_data", m_axis_tdata, 16'h0900);
    mon_en = 1'b0;
    #1;
    Reset = 1'b1;
    #1;
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_tdata", m_axis_tdata, 0);
    chk("midrst_tlast", m_axis_tlast, 0);
    chk("midrst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    Reset = 1'b0;
    m_axis_tready = 1'b1;
    for (int c = 0; c < 8; c++) push_exp(16'(27 * (256 + 16 * c)), c == 7);
    mon_en = 1'b1;
    run_channels(3);
    wait_drain();
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
